// File: rtl/rop_cfg_sequencer.sv
// ROP configuration sequencer: CSR shadow bank, in-flight fragment tracking,
// and drain-then-commit copy of the shadow bank into the active configuration.
module rop_cfg_sequencer #(
  parameter int CSR_ADDR_BITS = 4,
  parameter int INFLIGHT_BITS = 6
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     csr_wr_valid,
  input  logic [CSR_ADDR_BITS-1:0] csr_wr_addr,
  input  logic [31:0]              csr_wr_data,
  output logic                     csr_wr_ready,
  input  logic                     frag_issue,
  input  logic                     frag_retire,
  output logic                     rop_hold,
  output logic [31:0]              cfg_zbuf_addr,
  output logic [31:0]              cfg_zbuf_pitch,
  output logic [31:0]              cfg_cbuf_addr,
  output logic [31:0]              cfg_cbuf_pitch,
  output logic [31:0]              cfg_blend_const,
  output logic [2:0]               cfg_zfunc,
  output logic [2:0]               cfg_sfunc,
  output logic [2:0]               cfg_zfail,
  output logic [2:0]               cfg_zpass,
  output logic [2:0]               cfg_sfail,
  output logic [3:0]               cfg_blend_src_rgb,
  output logic [3:0]               cfg_blend_dst_rgb,
  output logic [3:0]               cfg_blend_src_a,
  output logic [3:0]               cfg_blend_dst_a,
  output logic [2:0]               cfg_blend_mode_rgb,
  output logic [2:0]               cfg_blend_mode_a,
  output logic [3:0]               cfg_logic_op,
  output logic [7:0]               cfg_gen,
  output logic                     err_underflow
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  localparam logic [INFLIGHT_BITS-1:0] CNT_MAX = '1;

  localparam logic [CSR_ADDR_BITS-1:0] A_ZBUF_ADDR   = CSR_ADDR_BITS'(0);
  localparam logic [CSR_ADDR_BITS-1:0] A_ZBUF_PITCH  = CSR_ADDR_BITS'(1);
  localparam logic [CSR_ADDR_BITS-1:0] A_CBUF_ADDR   = CSR_ADDR_BITS'(2);
  localparam logic [CSR_ADDR_BITS-1:0] A_CBUF_PITCH  = CSR_ADDR_BITS'(3);
  localparam logic [CSR_ADDR_BITS-1:0] A_ZSTENCIL    = CSR_ADDR_BITS'(4);
  localparam logic [CSR_ADDR_BITS-1:0] A_BLEND_FUNC  = CSR_ADDR_BITS'(5);
  localparam logic [CSR_ADDR_BITS-1:0] A_BLEND_MODE  = CSR_ADDR_BITS'(6);
  localparam logic [CSR_ADDR_BITS-1:0] A_BLEND_CONST = CSR_ADDR_BITS'(7);
  localparam logic [CSR_ADDR_BITS-1:0] A_LOGIC_OP    = CSR_ADDR_BITS'(8);
  localparam logic [CSR_ADDR_BITS-1:0] A_COMMIT      = CSR_ADDR_BITS'(9);

  typedef struct packed {
    logic [31:0] zbuf_addr;
    logic [31:0] zbuf_pitch;
    logic [31:0] cbuf_addr;
    logic [31:0] cbuf_pitch;
    logic [31:0] blend_const;
    logic [2:0]  zfunc;
    logic [2:0]  sfunc;
    logic [2:0]  zfail;
    logic [2:0]  zpass;
    logic [2:0]  sfail;
    logic [3:0]  blend_src_rgb;
    logic [3:0]  blend_dst_rgb;
    logic [3:0]  blend_src_a;
    logic [3:0]  blend_dst_a;
    logic [2:0]  blend_mode_rgb;
    logic [2:0]  blend_mode_a;
    logic [3:0]  logic_op;
  } cfg_t;

  logic [0:0]               state;
  logic [INFLIGHT_BITS-1:0] count;
  logic [INFLIGHT_BITS-1:0] count_nxt;
  logic                     underflow_set;
  logic                     wr_accept;
  cfg_t                     shadow;
  cfg_t                     active;

  assign csr_wr_ready = (state == ST_IDLE);
  assign wr_accept    = csr_wr_valid & csr_wr_ready;
  assign rop_hold     = (state == ST_DRAIN) | (count == CNT_MAX);

  // Issue saturates at max; retire at zero flags underflow instead of wrapping.
  always_comb begin
    count_nxt     = count;
    underflow_set = 1'b0;
    unique case ({frag_issue, frag_retire})
      2'b10: if (count != CNT_MAX) count_nxt = count + 1'b1;
      2'b01: if (count == '0) underflow_set = 1'b1;
             else count_nxt = count - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count         <= '0;
      err_underflow <= 1'b0;
    end else begin
      count <= count_nxt;
      if (underflow_set) err_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
    end else if (wr_accept) begin
      case (csr_wr_addr)
        A_ZBUF_ADDR:   shadow.zbuf_addr   <= csr_wr_data;
        A_ZBUF_PITCH:  shadow.zbuf_pitch  <= csr_wr_data;
        A_CBUF_ADDR:   shadow.cbuf_addr   <= csr_wr_data;
        A_CBUF_PITCH:  shadow.cbuf_pitch  <= csr_wr_data;
        A_ZSTENCIL: begin
          shadow.zfunc <= csr_wr_data[2:0];
          shadow.sfunc <= csr_wr_data[6:4];
          shadow.zfail <= csr_wr_data[10:8];
          shadow.zpass <= csr_wr_data[14:12];
          shadow.sfail <= csr_wr_data[18:16];
        end
        A_BLEND_FUNC: begin
          shadow.blend_src_rgb <= csr_wr_data[3:0];
          shadow.blend_dst_rgb <= csr_wr_data[11:8];
          shadow.blend_src_a   <= csr_wr_data[19:16];
          shadow.blend_dst_a   <= csr_wr_data[27:24];
        end
        A_BLEND_MODE: begin
          shadow.blend_mode_rgb <= csr_wr_data[2:0];
          shadow.blend_mode_a   <= csr_wr_data[10:8];
        end
        A_BLEND_CONST: shadow.blend_const <= csr_wr_data;
        A_LOGIC_OP:    shadow.logic_op    <= csr_wr_data[3:0];
        default: ;
      endcase
    end
  end

  // The whole bank moves in one edge, only once the registered count is empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      active  <= '0;
      cfg_gen <= '0;
    end else begin
      unique case (state)
        ST_IDLE:
          if (wr_accept && (csr_wr_addr == A_COMMIT)) state <= ST_DRAIN;
        ST_DRAIN:
          if (count == '0) begin
            active  <= shadow;
            cfg_gen <= cfg_gen + 8'd1;
            state   <= ST_IDLE;
          end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cfg_zbuf_addr      = active.zbuf_addr;
  assign cfg_zbuf_pitch     = active.zbuf_pitch;
  assign cfg_cbuf_addr      = active.cbuf_addr;
  assign cfg_cbuf_pitch     = active.cbuf_pitch;
  assign cfg_blend_const    = active.blend_const;
  assign cfg_zfunc          = active.zfunc;
  assign cfg_sfunc          = active.sfunc;
  assign cfg_zfail          = active.zfail;
  assign cfg_zpass          = active.zpass;
  assign cfg_sfail          = active.sfail;
  assign cfg_blend_src_rgb  = active.blend_src_rgb;
  assign cfg_blend_dst_rgb  = active.blend_dst_rgb;
  assign cfg_blend_src_a    = active.blend_src_a;
  assign cfg_blend_dst_a    = active.blend_dst_a;
  assign cfg_blend_mode_rgb = active.blend_mode_rgb;
  assign cfg_blend_mode_a   = active.blend_mode_a;
  assign cfg_logic_op       = active.logic_op;

endmodule

// File: tb/tb_rop_cfg_sequencer.sv
// Self-checking bench for rop_cfg_sequencer: register-map vector table,
// commit scoreboard, and directed drain / saturation / reset sequences.
module tb_rop_cfg_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        csr_wr_valid = 1'b0;
  logic [3:0]  csr_wr_addr = '0;
  logic [31:0] csr_wr_data = '0;
  logic        csr_wr_ready;
  logic        frag_issue = 1'b0;
  logic        frag_retire = 1'b0;
  logic        rop_hold;
  logic [31:0] cfg_zbuf_addr, cfg_zbuf_pitch, cfg_cbuf_addr, cfg_cbuf_pitch, cfg_blend_const;
  logic [2:0]  cfg_zfunc, cfg_sfunc, cfg_zfail, cfg_zpass, cfg_sfail;
  logic [3:0]  cfg_blend_src_rgb, cfg_blend_dst_rgb, cfg_blend_src_a, cfg_blend_dst_a;
  logic [2:0]  cfg_blend_mode_rgb, cfg_blend_mode_a;
  logic [3:0]  cfg_logic_op;
  logic [7:0]  cfg_gen;
  logic        err_underflow;

  always #5 clk = ~clk;

  rop_cfg_sequencer #(.CSR_ADDR_BITS(4), .INFLIGHT_BITS(6)) dut (
    .clk(clk), .reset_n(reset_n),
    .csr_wr_valid(csr_wr_valid), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .csr_wr_ready(csr_wr_ready),
    .frag_issue(frag_issue), .frag_retire(frag_retire), .rop_hold(rop_hold),
    .cfg_zbuf_addr(cfg_zbuf_addr), .cfg_zbuf_pitch(cfg_zbuf_pitch),
    .cfg_cbuf_addr(cfg_cbuf_addr), .cfg_cbuf_pitch(cfg_cbuf_pitch),
    .cfg_blend_const(cfg_blend_const),
    .cfg_zfunc(cfg_zfunc), .cfg_sfunc(cfg_sfunc), .cfg_zfail(cfg_zfail),
    .cfg_zpass(cfg_zpass), .cfg_sfail(cfg_sfail),
    .cfg_blend_src_rgb(cfg_blend_src_rgb), .cfg_blend_dst_rgb(cfg_blend_dst_rgb),
    .cfg_blend_src_a(cfg_blend_src_a), .cfg_blend_dst_a(cfg_blend_dst_a),
    .cfg_blend_mode_rgb(cfg_blend_mode_rgb), .cfg_blend_mode_a(cfg_blend_mode_a),
    .cfg_logic_op(cfg_logic_op), .cfg_gen(cfg_gen), .err_underflow(err_underflow)
  );

  typedef struct packed {
    logic [31:0] zbuf_addr, zbuf_pitch, cbuf_addr, cbuf_pitch, blend_const;
    logic [2:0]  zfunc, sfunc, zfail, zpass, sfail;
    logic [3:0]  bsrc_rgb, bdst_rgb, bsrc_a, bdst_a;
    logic [2:0]  bmode_rgb, bmode_a;
    logic [3:0]  logic_op;
    logic [7:0]  gen;
  } cfg_t;

  typedef struct {
    string       name;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   commit_cnt = 0;
  logic [7:0] last_gen = '0;
  cfg_t sh_m = '0;
  cfg_t cur_active = '0;
  cfg_t sb_q[$];
  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  function automatic cfg_t dut_cfg();
    cfg_t c;
    c.zbuf_addr = cfg_zbuf_addr;   c.zbuf_pitch = cfg_zbuf_pitch;
    c.cbuf_addr = cfg_cbuf_addr;   c.cbuf_pitch = cfg_cbuf_pitch;
    c.blend_const = cfg_blend_const;
    c.zfunc = cfg_zfunc; c.sfunc = cfg_sfunc; c.zfail = cfg_zfail;
    c.zpass = cfg_zpass; c.sfail = cfg_sfail;
    c.bsrc_rgb = cfg_blend_src_rgb; c.bdst_rgb = cfg_blend_dst_rgb;
    c.bsrc_a = cfg_blend_src_a;     c.bdst_a = cfg_blend_dst_a;
    c.bmode_rgb = cfg_blend_mode_rgb; c.bmode_a = cfg_blend_mode_a;
    c.logic_op = cfg_logic_op; c.gen = cfg_gen;
    return c;
  endfunction

  task automatic cmp_cfg(input string name, input cfg_t exp);
    cfg_t act = dut_cfg();
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got bank 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Active outputs repacked into the register layout used by the CSR map.
  function automatic logic [31:0] field_of(input logic [3:0] a);
    case (a)
      4'd0: return cfg_zbuf_addr;
      4'd1: return cfg_zbuf_pitch;
      4'd2: return cfg_cbuf_addr;
      4'd3: return cfg_cbuf_pitch;
      4'd4: return {13'd0, cfg_sfail, 1'b0, cfg_zpass, 1'b0, cfg_zfail, 1'b0, cfg_sfunc, 1'b0, cfg_zfunc};
      4'd5: return {4'd0, cfg_blend_dst_a, 4'd0, cfg_blend_src_a, 4'd0, cfg_blend_dst_rgb, 4'd0, cfg_blend_src_rgb};
      4'd6: return {21'd0, cfg_blend_mode_a, 5'd0, cfg_blend_mode_rgb};
      4'd7: return cfg_blend_const;
      default: return {28'd0, cfg_logic_op};
    endcase
  endfunction

  function automatic void model_write(input logic [3:0] a, input logic [31:0] d);
    cfg_t e;
    case (a)
      4'd0: sh_m.zbuf_addr = d;
      4'd1: sh_m.zbuf_pitch = d;
      4'd2: sh_m.cbuf_addr = d;
      4'd3: sh_m.cbuf_pitch = d;
      4'd4: begin
        sh_m.zfunc = d[2:0];   sh_m.sfunc = d[6:4];   sh_m.zfail = d[10:8];
        sh_m.zpass = d[14:12]; sh_m.sfail = d[18:16];
      end
      4'd5: begin
        sh_m.bsrc_rgb = d[3:0];   sh_m.bdst_rgb = d[11:8];
        sh_m.bsrc_a   = d[19:16]; sh_m.bdst_a   = d[27:24];
      end
      4'd6: begin sh_m.bmode_rgb = d[2:0]; sh_m.bmode_a = d[10:8]; end
      4'd7: sh_m.blend_const = d;
      4'd8: sh_m.logic_op = d[3:0];
      4'd9: begin
        commit_cnt++;
        e = sh_m;
        e.gen = 8'(commit_cnt);
        sb_q.push_back(e);
      end
      default: ;
    endcase
  endfunction

  task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
    chk("wr_ready_idle", 32'(csr_wr_ready), 32'd1);
    csr_wr_valid = 1'b1; csr_wr_addr = a; csr_wr_data = d;
    tick();
    csr_wr_valid = 1'b0;
    model_write(a, d);
  endtask

  task automatic wait_commit(input int budget);
    bit   got = 1'b0;
    cfg_t e;
    for (int i = 0; i <= budget; i++) begin
      if (cfg_gen !== last_gen) begin got = 1'b1; break; end
      if (i < budget) tick();
    end
    chk("commit_seen", 32'(got), 32'd1);
    if (got) begin
      chk("sb_depth", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp_cfg("commit_bank", e);
        cur_active = e;
        last_gen = e.gen;
      end
    end
  endtask

  task automatic issue_n(input int n);
    frag_issue = 1'b1;
    repeat (n) tick();
    frag_issue = 1'b0;
  endtask

  task automatic retire_n(input int n);
    frag_retire = 1'b1;
    repeat (n) tick();
    frag_retire = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"zbuf_addr",    4'd0,  32'hA5A5_0001, 32'hA5A5_0001};
    vecs[1]  = '{"zbuf_pitch",   4'd1,  32'h0000_1000, 32'h0000_1000};
    vecs[2]  = '{"cbuf_addr",    4'd2,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3]  = '{"cbuf_pitch",   4'd3,  32'h0000_2000, 32'h0000_2000};
    vecs[4]  = '{"zstencil_ign", 4'd4,  32'hFFFF_FFFF, 32'h0007_7777};
    vecs[5]  = '{"blend_f_ign",  4'd5,  32'hFFFF_FFFF, 32'h0F0F_0F0F};
    vecs[6]  = '{"blend_func",   4'd5,  32'h1234_5678, 32'h0204_0608};
    vecs[7]  = '{"blend_mode",   4'd6,  32'hFFFF_FFFE, 32'h0000_0706};
    vecs[8]  = '{"blend_const",  4'd7,  32'h1234_5678, 32'h1234_5678};
    vecs[9]  = '{"logic_op",     4'd8,  32'hFFFF_FFF9, 32'h0000_0009};
    vecs[10] = '{"discard_10",   4'd10, 32'hFFFF_FFFF, 32'h0};
    vecs[11] = '{"discard_15",   4'd15, 32'h5A5A_5A5A, 32'h0};

    // Reset state, both while held and after release.
    repeat (3) tick();
    cmp_cfg("reset_bank_held", cur_active);
    chk("reset_ready", 32'(csr_wr_ready), 32'd1);
    chk("reset_hold", 32'(rop_hold), 32'd0);
    chk("reset_err", 32'(err_underflow), 32'd0);
    reset_n = 1'b1;
    tick();
    cmp_cfg("reset_bank", cur_active);

    // Basic commit with exact latency.
    csr_write(4'd0, 32'h1000_0000);
    csr_write(4'd4, 32'h0001_2345);
    chk("zbuf_before_commit", cfg_zbuf_addr, 32'h0);
    csr_write(4'd9, 32'h0);
    chk("commit_t1_hold", 32'(rop_hold), 32'd1);
    chk("commit_t1_ready", 32'(csr_wr_ready), 32'd0);
    chk("commit_t1_zbuf", cfg_zbuf_addr, 32'h0);
    chk("commit_t1_gen", 32'(cfg_gen), 32'd0);
    tick();
    chk("commit_t2_zbuf", cfg_zbuf_addr, 32'h1000_0000);
    chk("commit_t2_zfunc", 32'(cfg_zfunc), 32'd5);
    chk("commit_t2_sfunc", 32'(cfg_sfunc), 32'd4);
    chk("commit_t2_zfail", 32'(cfg_zfail), 32'd3);
    chk("commit_t2_zpass", 32'(cfg_zpass), 32'd2);
    chk("commit_t2_sfail", 32'(cfg_sfail), 32'd1);
    chk("commit_t2_gen", 32'(cfg_gen), 32'd1);
    chk("commit_t2_hold", 32'(rop_hold), 32'd0);
    chk("commit_t2_ready", 32'(csr_wr_ready), 32'd1);
    wait_commit(2);

    // Register map vectors, one commit each.
    for (int i = 0; i < 12; i++) begin
      csr_write(vecs[i].addr, vecs[i].data);
      cmp_cfg("hold_until_commit", cur_active);
      csr_write(4'd9, $urandom);
      wait_commit(4);
      if (vecs[i].addr <= 4'd8) chk(vecs[i].name, field_of(vecs[i].addr), vecs[i].exp);
    end

    // Drain with three fragments in flight, retire every fourth cycle.
    csr_write(4'd1, 32'h0000_4444);
    issue_n(3);
    csr_write(4'd9, 32'h0);
    chk("drain_hold", 32'(rop_hold), 32'd1);
    chk("drain_ready", 32'(csr_wr_ready), 32'd0);
    repeat (3) tick();
    retire_n(1);
    frag_issue = 1'b1; frag_retire = 1'b1;
    tick();
    frag_issue = 1'b0; frag_retire = 1'b0;
    csr_wr_valid = 1'b1; csr_wr_addr = 4'd1; csr_wr_data = 32'hBAD0_BAD0;
    repeat (3) tick();
    csr_wr_valid = 1'b0;
    chk("drain_gen_hold", 32'(cfg_gen), 32'(last_gen));
    chk("drain_still_hold", 32'(rop_hold), 32'd1);
    retire_n(1);
    repeat (3) tick();
    chk("drain_gen_2", 32'(cfg_gen), 32'(last_gen));
    retire_n(1);
    chk("drain_last_retire_gen", 32'(cfg_gen), 32'(last_gen));
    chk("drain_last_retire_hold", 32'(rop_hold), 32'd1);
    tick();
    chk("drain_done_gen", 32'(cfg_gen), 32'(8'(last_gen + 8'd1)));
    chk("drain_done_hold", 32'(rop_hold), 32'd0);
    wait_commit(2);

    // Underflow is sticky and leaves the count at zero.
    chk("underflow_pre", 32'(err_underflow), 32'd0);
    retire_n(1);
    chk("underflow_set", 32'(err_underflow), 32'd1);
    repeat (3) tick();
    chk("underflow_sticky", 32'(err_underflow), 32'd1);
    chk("underflow_hold", 32'(rop_hold), 32'd0);

    // Saturation at 63.
    issue_n(62);
    chk("sat_62_hold", 32'(rop_hold), 32'd0);
    issue_n(1);
    chk("sat_63_hold", 32'(rop_hold), 32'd1);
    issue_n(1);
    chk("sat_extra_hold", 32'(rop_hold), 32'd1);
    retire_n(1);
    chk("sat_retire_hold", 32'(rop_hold), 32'd0);
    retire_n(62);
    csr_write(4'd9, 32'h0);
    wait_commit(3);
    chk("underflow_after_sat", 32'(err_underflow), 32'd1);

    // Wrap cfg_gen, then reset in the middle of a drain.
    while (commit_cnt < 256) begin
      csr_write(4'd9, 32'h0);
      wait_commit(4);
    end
    chk("gen_wrapped", 32'(cfg_gen), 32'd0);
    csr_write(4'd0, 32'h5555_5555);
    issue_n(1);
    csr_write(4'd9, 32'h0);
    repeat (2) tick();
    chk("pre_reset_hold", 32'(rop_hold), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    cur_active = '0;
    cmp_cfg("async_reset_bank", cur_active);
    chk("async_reset_ready", 32'(csr_wr_ready), 32'd1);
    chk("async_reset_hold", 32'(rop_hold), 32'd0);
    chk("async_reset_err", 32'(err_underflow), 32'd0);
    sb_q.delete();
    sh_m = '0; commit_cnt = 0; last_gen = '0;
    tick();
    reset_n = 1'b1;
    tick();
    csr_write(4'd9, 32'h0);
    wait_commit(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
